// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_if
// Description : Enqueue, drain, status and forwarding bundle for store_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
);
    logic                enq_valid;
    logic [31:0]         enq_addr;
    logic [31:0]         enq_data;
    logic [3:0]          enq_byte_en;

    logic                sb_full;
    logic                sb_empty;
    logic [PTR_BITS:0]   sb_count;

    logic                drain_ready;
    logic                drain_valid;
    logic [31:0]         drain_addr;
    logic [31:0]         drain_data;
    logic [3:0]          drain_byte_en;

    logic [31:0]         ld_addr;
    logic [3:0]          fwd_byte_en;
    logic [31:0]         fwd_data;
    logic                fwd_full;

    // D-cache side
    modport master (
        output enq_valid, enq_addr, enq_data, enq_byte_en, drain_ready, ld_addr,
        input  sb_full, sb_empty, sb_count, drain_valid, drain_addr, drain_data,
               drain_byte_en, fwd_byte_en, fwd_data, fwd_full
    );

    // Buffer side
    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_byte_en, drain_ready, ld_addr,
        output sb_full, sb_empty, sb_count, drain_valid, drain_addr, drain_data,
               drain_byte_en, fwd_byte_en, fwd_data, fwd_full
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : In-order committed-store FIFO with store-to-load byte forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    store_buffer_if.slave  sb
);

    localparam logic [PTR_BITS:0]   c_FULL_COUNT = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0]   c_CNT_ONE    = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS-1:0] c_PTR_ONE    = PTR_BITS'(1);

    logic [DEPTH-1:0]    r_valid;
    logic [29:0]         r_waddr [DEPTH];
    logic [31:0]         r_data  [DEPTH];
    logic [3:0]          r_be    [DEPTH];
    logic [PTR_BITS-1:0] r_head;
    logic [PTR_BITS-1:0] r_tail;
    logic [PTR_BITS:0]   r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_enq;
    logic                w_deq;
    logic [PTR_BITS-1:0] w_fwd_idx;
    logic [3:0]          w_fwd_be;
    logic [31:0]         w_fwd_data;
    logic                w_unused;

    // Byte offsets only select lanes; entries are keyed by word address.
    assign w_unused = ^{sb.enq_addr[1:0], sb.ld_addr[1:0]};

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_enq   = sb.enq_valid && !w_full && (sb.enq_byte_en != 4'b0000);
    assign w_deq   = !w_empty && sb.drain_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
                r_data[i]  <= '0;
                r_be[i]    <= '0;
            end
        end else begin
            // Full/empty gating keeps head and tail slots distinct when both fire.
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_waddr[r_tail] <= sb.enq_addr[31:2];
                r_data[r_tail]  <= sb.enq_data;
                r_be[r_tail]    <= sb.enq_byte_en;
                r_tail          <= r_tail + c_PTR_ONE;
            end
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign sb.sb_full       = w_full;
    assign sb.sb_empty      = w_empty;
    assign sb.sb_count      = r_count;
    assign sb.drain_valid   = !w_empty;
    assign sb.drain_addr    = w_empty ? 32'h0 : {r_waddr[r_head], 2'b00};
    assign sb.drain_data    = w_empty ? 32'h0 : r_data[r_head];
    assign sb.drain_byte_en = w_empty ? 4'h0  : r_be[r_head];

    // Walk oldest to youngest relative to head so later writers overwrite lanes.
    always_comb begin
        w_fwd_be   = 4'h0;
        w_fwd_data = 32'h0;
        w_fwd_idx  = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_head + PTR_BITS'(k);
            if (r_valid[w_fwd_idx] && (r_waddr[w_fwd_idx] == sb.ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_be[w_fwd_idx][b]) begin
                        w_fwd_be[b]          = 1'b1;
                        w_fwd_data[8*b +: 8] = r_data[w_fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign sb.fwd_byte_en = w_fwd_be;
    assign sb.fwd_data    = w_fwd_data;
    assign sb.fwd_full    = (w_fwd_be == 4'hF);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Scoreboard bench for store_buffer with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH    = 4;
    localparam int PTR_BITS = 2;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   m_count;
    ent_t exp_q[$];

    store_buffer_if #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) sb ();

    store_buffer #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; the model commits its view of the edge when the edge happens.
    task automatic step(input bit ev, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit dr);
        bit acc;
        bit deq;
        sb.enq_valid   = ev;
        sb.enq_addr    = a;
        sb.enq_data    = d;
        sb.enq_byte_en = be;
        sb.drain_ready = dr;
        acc = ev && (m_count < DEPTH) && (be != 4'h0);
        deq = dr && (m_count > 0);
        @(posedge clk);
        if (acc) exp_q.push_back('{w: a[31:2], d: d, be: be});
        m_count = m_count + int'(acc) - int'(deq);
        #1;
    endtask

    // Monitor: compare status, drain head and forwarding against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [3:0]  mbe;
                logic [31:0] md;
                mbe = 4'h0;
                md  = 32'h0;
                foreach (exp_q[i]) begin
                    if (exp_q[i].w == sb.ld_addr[31:2]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (exp_q[i].be[b]) begin
                                mbe[b]      = 1'b1;
                                md[8*b +: 8] = exp_q[i].d[8*b +: 8];
                            end
                        end
                    end
                end
                chk("sb_count", 32'(sb.sb_count), 32'(exp_q.size()));
                chk("sb_full",  32'(sb.sb_full),  32'(exp_q.size() == DEPTH));
                chk("sb_empty", 32'(sb.sb_empty), 32'(exp_q.size() == 0));
                chk("fwd_byte_en", 32'(sb.fwd_byte_en), 32'(mbe));
                chk("fwd_data", sb.fwd_data, md);
                chk("fwd_full", 32'(sb.fwd_full), 32'(mbe == 4'hF));
                if (exp_q.size() > 0) begin
                    chk("drain_valid", 32'(sb.drain_valid), 32'd1);
                    chk("drain_addr", sb.drain_addr, {exp_q[0].w, 2'b00});
                    chk("drain_data", sb.drain_data, exp_q[0].d);
                    chk("drain_byte_en", 32'(sb.drain_byte_en), 32'(exp_q[0].be));
                    if (sb.drain_ready) void'(exp_q.pop_front());
                end else begin
                    chk("drain_valid_idle", 32'(sb.drain_valid), 32'd0);
                    chk("drain_addr_idle", sb.drain_addr, 32'h0);
                    chk("drain_data_idle", sb.drain_data, 32'h0);
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        m_count = 0;
        reset   = 1'b0;
        sb.enq_valid   = 1'b0;
        sb.enq_addr    = 32'h0;
        sb.enq_data    = 32'h0;
        sb.enq_byte_en = 4'h0;
        sb.drain_ready = 1'b0;
        sb.ld_addr     = 32'h0;
        #2;
        chk("rst_drain_valid", 32'(sb.drain_valid), 32'd0);
        chk("rst_sb_empty", 32'(sb.sb_empty), 32'd1);
        chk("rst_fwd_be", 32'(sb.fwd_byte_en), 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("idle_sb_count", 32'(sb.sb_count), 32'd0);

        // Single store held under back-pressure, then drained
        sb.ld_addr = 32'h100;
        step(1, 32'h100, 32'hAABBCCDD, 4'hF, 0);
        chk("single_drain_valid", 32'(sb.drain_valid), 32'd1);
        chk("single_drain_addr", sb.drain_addr, 32'h100);
        chk("single_drain_data", sb.drain_data, 32'hAABBCCDD);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("single_empty", 32'(sb.sb_empty), 32'd1);

        // Overfill: fifth store is dropped
        for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(4*i), 32'h5000 + 32'(i), 4'hF, 0);
        chk("overfill_full", 32'(sb.sb_full), 32'd1);
        chk("overfill_count", 32'(sb.sb_count), 32'd4);
        repeat (4) step(0, 0, 0, 0, 1);
        chk("overfill_drained_empty", 32'(sb.sb_empty), 32'd1);

        // Full with simultaneous enqueue and drain: enqueue rejected
        for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(4*i), 32'h6000 + 32'(i), 4'hF, 0);
        step(1, 32'h4F0, 32'hDEADBEEF, 4'hF, 1);
        chk("full_enq_drain_count", 32'(sb.sb_count), 32'd3);
        repeat (3) step(0, 0, 0, 0, 1);

        // Youngest writer wins per lane; other word misses
        step(1, 32'h200, 32'h11223344, 4'hF, 0);
        step(1, 32'h200, 32'h0000AA00, 4'h2, 0);
        sb.ld_addr = 32'h202;
        #1;
        chk("fwd_merge_data", sb.fwd_data, 32'h1122AA44);
        chk("fwd_merge_full", 32'(sb.fwd_full), 32'd1);
        sb.ld_addr = 32'h204;
        #1;
        chk("fwd_miss_be", 32'(sb.fwd_byte_en), 32'd0);
        step(1, 32'h208, 32'h99, 4'h0, 0);
        chk("zero_be_ignored", 32'(sb.sb_count), 32'd2);
        repeat (2) step(0, 0, 0, 0, 1);

        // Steady state at occupancy one
        step(1, 32'h500, 32'h7000, 4'hF, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 32'h500 + 32'(4*i), 32'h7000 + 32'(i), 4'(i), 1);
            chk("steady_count", 32'(sb.sb_count), 32'd1);
        end
        step(0, 0, 0, 0, 1);

        // Asynchronous reset with three entries in flight
        for (int i = 0; i < 3; i++) step(1, 32'h600 + 32'(4*i), 32'h8000 + 32'(i), 4'hF, 0);
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_count = 0;
        #1;
        chk("async_rst_drain_valid", 32'(sb.drain_valid), 32'd0);
        chk("async_rst_count", 32'(sb.sb_count), 32'd0);
        step(0, 0, 0, 0, 0);
        reset = 1'b1;

        // Randomized traffic over a small set of aliasing words
        for (int n = 0; n < 400; n++) begin
            sb.ld_addr = 32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 7),
                 32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                 $urandom(), 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
        end
        repeat (DEPTH + 1) step(0, 0, 0, 0, 1);
        chk("final_empty", 32'(sb.sb_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
